// File: rtl/jogo_sequencia_param_pkg.sv
// Shared definitions for the sequence game: state encodings (these are the
// db_estado codes), the default LFSR seed and the LFSR step function.
package jogo_sequencia_param_pkg;

    typedef enum logic [3:0] {
        INICIAL     = 4'h0,
        PREPARA     = 4'h1,
        GERA        = 4'h2,
        MOSTRA      = 4'h3,
        APAGA       = 4'h4,
        ESPERA      = 4'h5,
        COMPARA     = 4'h6,
        FIM_ACERTO  = 4'hA,
        FIM_ERRO    = 4'hE,
        FIM_TIMEOUT = 4'hF
    } estado_t;

    // Seed for the repeatable game, also the substitute for an all-zero seed
    // (an all-zero LFSR would lock up).
    localparam logic [15:0] SEMENTE_PADRAO = 16'hACE1;

    // One step of the 16-bit Fibonacci LFSR, taps 16,14,13,11 (right-shift form).
    function automatic logic [15:0] lfsr_passo(input logic [15:0] q);
        return {q[0] ^ q[2] ^ q[3] ^ q[5], q[15:1]};
    endfunction

endpackage

// File: rtl/jogo_sequencia_param_lfsr.sv
// 16-bit LFSR used as the pseudo-random source of the game sequence.
// carrega has priority over avanca; a zero seed is replaced by the default.
module lfsr_16
    import jogo_sequencia_param_pkg::*;
(
    input  logic        clock,
    input  logic        reset,
    input  logic        carrega,
    input  logic [15:0] semente,
    input  logic        avanca,
    output logic [15:0] q
);

    logic [15:0] q_r;

    // LFSR register: load seed, step, or hold.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            q_r <= SEMENTE_PADRAO;
        end else if (carrega) begin
            if (semente == 16'h0000) begin
                q_r <= SEMENTE_PADRAO;
            end else begin
                q_r <= semente;
            end
        end else if (avanca) begin
            q_r <= lfsr_passo(q_r);
        end else begin
            q_r <= q_r;
        end
    end

    assign q = q_r;

endmodule

// File: rtl/jogo_sequencia_param.sv
// Memory-sequence game ("Simon"): shows a growing pseudo-random sequence on
// one-hot LEDs and checks the player's button presses against it.
// Outputs are registered from the next-state values so they line up with
// the state register (db_estado) cycle for cycle.
module jogo_sequencia_param
    import jogo_sequencia_param_pkg::*;
#(
    parameter int N         = 4,
    parameter int A         = 4,
    parameter int T_MOSTRA  = 500,
    parameter int T_TIMEOUT = 5000
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         iniciar,
    input  logic         modo,
    input  logic [N-1:0] botoes,
    output logic [N-1:0] leds,
    output logic         pronto,
    output logic         acertou,
    output logic         errou,
    output logic         timeout,
    output logic [3:0]   db_estado,
    output logic [A-1:0] db_rodada,
    output logic [A-1:0] db_endereco,
    output logic [N-1:0] db_jogada
);

    localparam int IW    = $clog2(N);
    localparam int L     = 1 << A;
    localparam int T_MAX = (T_TIMEOUT > T_MOSTRA) ? T_TIMEOUT : T_MOSTRA;
    localparam int TW    = $clog2(T_MAX) + 1;

    localparam logic [TW-1:0] FIM_MOSTRA  = TW'(T_MOSTRA - 1);
    localparam logic [TW-1:0] FIM_APAGA   = TW'((T_MOSTRA / 2) - 1);
    localparam logic [TW-1:0] FIM_ESPERA  = TW'(T_TIMEOUT - 1);
    localparam logic [A-1:0]  RODADA_MAX  = A'(L - 1);

    // Index to one-hot LED/button pattern.
    function automatic logic [N-1:0] para_onehot(input logic [IW-1:0] idx);
        logic [N-1:0] v;
        v      = {N{1'b0}};
        v[idx] = 1'b1;
        return v;
    endfunction

    // True when exactly one bit is set.
    function automatic logic eh_onehot(input logic [N-1:0] v);
        return (v != {N{1'b0}}) && ((v & (v - N'(1))) == {N{1'b0}});
    endfunction

    estado_t        estado_r, estado_s;
    logic [A-1:0]   rodada_r, rodada_s;
    logic [A-1:0]   endereco_r, endereco_s;
    logic [TW-1:0]  timer_r, timer_s;
    logic [N-1:0]   jogada_r, jogada_s;
    logic           botao_ant_r;
    logic [15:0]    cont_livre_r;
    logic [IW-1:0]  mem_r [L];

    logic           carrega_s;
    logic           avanca_s;
    logic           mem_we_s;
    logic [15:0]    semente_bruta_s;
    logic [15:0]    semente_s;
    logic [15:0]    lfsr_q_s;
    logic           jogada_det_s;
    logic           acerto_s;
    logic [IW-1:0]  mem_rd_s;

    logic [N-1:0]   leds_r, leds_s;
    logic           pronto_r, pronto_s;
    logic           acertou_r, acertou_s;
    logic           errou_r, errou_s;
    logic           timeout_r, timeout_s;

    lfsr_16 u_lfsr (
        .clock   (clock),
        .reset   (reset),
        .carrega (carrega_s),
        .semente (semente_s),
        .avanca  (avanca_s),
        .q       (lfsr_q_s)
    );

    // A play is the rising edge of "any button": a button already held when
    // waiting starts must be released before it can count.
    assign jogada_det_s = (|botoes) & ~botao_ant_r;

    // Captured play must be a single button matching the current element.
    assign acerto_s = eh_onehot(jogada_r) && (jogada_r == para_onehot(mem_r[endereco_r]));

    // Seed selection: fixed seed or free-running counter, never zero.
    always_comb begin
        semente_bruta_s = SEMENTE_PADRAO;
        semente_s       = SEMENTE_PADRAO;
        if (modo) begin
            semente_bruta_s = cont_livre_r;
        end else begin
            semente_bruta_s = SEMENTE_PADRAO;
        end
        if (semente_bruta_s == 16'h0000) begin
            semente_s = SEMENTE_PADRAO;
        end else begin
            semente_s = semente_bruta_s;
        end
    end

    // Next-state logic and datapath control.
    always_comb begin
        estado_s   = estado_r;
        rodada_s   = rodada_r;
        endereco_s = endereco_r;
        timer_s    = timer_r;
        jogada_s   = jogada_r;
        carrega_s  = 1'b0;
        avanca_s   = 1'b0;
        mem_we_s   = 1'b0;
        case (estado_r)
            INICIAL: begin
                if (iniciar) begin
                    estado_s = PREPARA;
                end else begin
                    estado_s = INICIAL;
                end
            end
            PREPARA: begin
                rodada_s   = {A{1'b0}};
                endereco_s = {A{1'b0}};
                timer_s    = {TW{1'b0}};
                carrega_s  = 1'b1;
                estado_s   = GERA;
            end
            GERA: begin
                mem_we_s   = 1'b1;
                avanca_s   = 1'b1;
                endereco_s = {A{1'b0}};
                timer_s    = {TW{1'b0}};
                estado_s   = MOSTRA;
            end
            MOSTRA: begin
                if (timer_r == FIM_MOSTRA) begin
                    timer_s  = {TW{1'b0}};
                    estado_s = APAGA;
                end else begin
                    timer_s  = timer_r + TW'(1);
                end
            end
            APAGA: begin
                if (timer_r == FIM_APAGA) begin
                    timer_s = {TW{1'b0}};
                    if (endereco_r == rodada_r) begin
                        endereco_s = {A{1'b0}};
                        estado_s   = ESPERA;
                    end else begin
                        endereco_s = endereco_r + A'(1);
                        estado_s   = MOSTRA;
                    end
                end else begin
                    timer_s = timer_r + TW'(1);
                end
            end
            ESPERA: begin
                // A play in the last waiting cycle wins over the timeout.
                if (jogada_det_s) begin
                    jogada_s = botoes;
                    timer_s  = {TW{1'b0}};
                    estado_s = COMPARA;
                end else if (timer_r == FIM_ESPERA) begin
                    timer_s  = {TW{1'b0}};
                    estado_s = FIM_TIMEOUT;
                end else begin
                    timer_s  = timer_r + TW'(1);
                end
            end
            COMPARA: begin
                if (!acerto_s) begin
                    estado_s = FIM_ERRO;
                end else if (endereco_r < rodada_r) begin
                    endereco_s = endereco_r + A'(1);
                    timer_s    = {TW{1'b0}};
                    estado_s   = ESPERA;
                end else if (rodada_r != RODADA_MAX) begin
                    rodada_s = rodada_r + A'(1);
                    estado_s = GERA;
                end else begin
                    estado_s = FIM_ACERTO;
                end
            end
            FIM_ACERTO, FIM_ERRO, FIM_TIMEOUT: begin
                if (iniciar) begin
                    estado_s = PREPARA;
                end else begin
                    estado_s = estado_r;
                end
            end
            default: begin
                estado_s = INICIAL;
            end
        endcase
    end

    // Element shown next cycle; forwards the value being written in GERA.
    always_comb begin
        mem_rd_s = mem_r[endereco_s];
        if (mem_we_s && (rodada_r == endereco_s)) begin
            mem_rd_s = lfsr_q_s[IW-1:0];
        end else begin
            mem_rd_s = mem_r[endereco_s];
        end
    end

    // Output values for the next cycle, derived from the next state.
    always_comb begin
        leds_s    = {N{1'b0}};
        pronto_s  = 1'b0;
        acertou_s = 1'b0;
        errou_s   = 1'b0;
        timeout_s = 1'b0;
        case (estado_s)
            MOSTRA: begin
                leds_s = para_onehot(mem_rd_s);
            end
            FIM_ACERTO: begin
                pronto_s  = 1'b1;
                acertou_s = 1'b1;
            end
            FIM_ERRO: begin
                pronto_s = 1'b1;
                errou_s  = 1'b1;
            end
            FIM_TIMEOUT: begin
                pronto_s  = 1'b1;
                timeout_s = 1'b1;
            end
            default: begin
                leds_s = {N{1'b0}};
            end
        endcase
    end

    // State, counters and captured play.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            estado_r    <= INICIAL;
            rodada_r    <= {A{1'b0}};
            endereco_r  <= {A{1'b0}};
            timer_r     <= {TW{1'b0}};
            jogada_r    <= {N{1'b0}};
            botao_ant_r <= 1'b0;
        end else begin
            estado_r    <= estado_s;
            rodada_r    <= rodada_s;
            endereco_r  <= endereco_s;
            timer_r     <= timer_s;
            jogada_r    <= jogada_s;
            botao_ant_r <= |botoes;
        end
    end

    // Free-running seed counter, independent of game state.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            cont_livre_r <= 16'h0000;
        end else begin
            cont_livre_r <= cont_livre_r + 16'h0001;
        end
    end

    // Sequence memory; contents are irrelevant after reset.
    always_ff @(posedge clock) begin
        if (mem_we_s) begin
            mem_r[rodada_r] <= lfsr_q_s[IW-1:0];
        end
    end

    // Registered outputs.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            leds_r    <= {N{1'b0}};
            pronto_r  <= 1'b0;
            acertou_r <= 1'b0;
            errou_r   <= 1'b0;
            timeout_r <= 1'b0;
        end else begin
            leds_r    <= leds_s;
            pronto_r  <= pronto_s;
            acertou_r <= acertou_s;
            errou_r   <= errou_s;
            timeout_r <= timeout_s;
        end
    end

    assign leds        = leds_r;
    assign pronto      = pronto_r;
    assign acertou     = acertou_r;
    assign errou       = errou_r;
    assign timeout     = timeout_r;
    assign db_estado   = estado_r;
    assign db_rodada   = rodada_r;
    assign db_endereco = endereco_r;
    assign db_jogada   = jogada_r;

endmodule

// File: tb/tb_jogo_sequencia_param.sv
// Directed bench for jogo_sequencia_param (N=4, A=4, short display time to
// keep a full 16-round game short; the timeout keeps its default 5000).
module tb_jogo_sequencia_param;

    localparam int N  = 4;
    localparam int A  = 4;
    localparam int L  = 16;
    localparam int TM = 20;
    localparam int TT = 5000;

    logic         clock = 1'b0;
    logic         reset;
    logic         iniciar;
    logic         modo;
    logic [N-1:0] botoes;
    logic [N-1:0] leds;
    logic         pronto, acertou, errou, timeout;
    logic [3:0]   db_estado;
    logic [A-1:0] db_rodada, db_endereco;
    logic [N-1:0] db_jogada;

    int n_checks = 0;
    int n_pass   = 0;
    logic [1:0] exp_seq [L];

    jogo_sequencia_param #(.N(N), .A(A), .T_MOSTRA(TM), .T_TIMEOUT(TT)) dut (
        .clock       (clock),
        .reset       (reset),
        .iniciar     (iniciar),
        .modo        (modo),
        .botoes      (botoes),
        .leds        (leds),
        .pronto      (pronto),
        .acertou     (acertou),
        .errou       (errou),
        .timeout     (timeout),
        .db_estado   (db_estado),
        .db_rodada   (db_rodada),
        .db_endereco (db_endereco),
        .db_jogada   (db_jogada)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clock);
            #1;
        end
    endtask

    task automatic wait_state(input string tag, input logic [3:0] code, input int budget);
        int k;
        k = 0;
        while (db_estado !== code && k < budget) begin
            tick(1);
            k++;
        end
        check(tag, 32'(db_estado), 32'(code));
    endtask

    function automatic logic [3:0] oh(input logic [1:0] i);
        logic [3:0] v;
        v = 4'b0001 << i;
        return v;
    endfunction

    task automatic press(input string tag, input logic [3:0] b);
        botoes = b;
        tick(1);
        check({tag, "_compara"}, 32'(db_estado), 32'h6);
        check({tag, "_jogada"}, 32'(db_jogada), 32'(b));
        botoes = 4'b0000;
        tick(1);
    endtask

    task automatic start_game();
        iniciar = 1'b1;
        tick(1);
        check("prepara", 32'(db_estado), 32'h1);
        check("flags_clear", 32'({pronto, acertou, errou, timeout}), 32'h0);
        iniciar = 1'b0;
    endtask

    task automatic play_round(input int r);
        wait_state("espera_round", 4'h5, 5000);
        for (int e = 0; e <= r; e++) begin
            press("play", oh(exp_seq[e]));
        end
    endtask

    // Watchdog so the run always ends.
    initial begin
        #3000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int k;
        logic [15:0] s;
        s = 16'hACE1;
        for (int i = 0; i < L; i++) begin
            exp_seq[i] = s[1:0];
            s = {s[0] ^ s[2] ^ s[3] ^ s[5], s[15:1]};
        end

        reset = 1'b1; iniciar = 1'b0; modo = 1'b0; botoes = 4'b0000;
        tick(3);
        check("rst_estado", 32'(db_estado), 32'h0);
        check("rst_leds", 32'(leds), 32'h0);
        check("rst_flags", 32'({pronto, acertou, errou, timeout}), 32'h0);
        check("rst_dbg", 32'({db_rodada, db_endereco, db_jogada}), 32'h0);
        reset = 1'b0;
        tick(2);
        check("idle", 32'(db_estado), 32'h0);

        // First game: timing of display, then a full correct game.
        start_game();
        tick(1);
        check("gera", 32'(db_estado), 32'h2);
        tick(1);
        check("mostra", 32'(db_estado), 32'h3);
        check("leds_first", 32'(leds), 32'h2);
        k = 0;
        while (leds == 4'b0010 && db_estado == 4'h3 && k < 1000) begin tick(1); k++; end
        check("mostra_len", 32'(k), 32'(TM));
        check("apaga", 32'(db_estado), 32'h4);
        k = 0;
        while (leds == 4'b0000 && db_estado == 4'h4 && k < 1000) begin tick(1); k++; end
        check("apaga_len", 32'(k), 32'(TM / 2));
        check("espera", 32'(db_estado), 32'h5);
        for (int r = 0; r < L; r++) play_round(r);
        check("fim_acerto", 32'(db_estado), 32'hA);
        check("acerto_flags", 32'({pronto, acertou, errou, timeout}), 32'hC);
        check("acerto_leds", 32'(leds), 32'h0);
        check("acerto_rodada", 32'(db_rodada), 32'(L - 1));

        // Wrong button in round 2 at address 1.
        start_game();
        play_round(0);
        play_round(1);
        wait_state("espera_r2", 4'h5, 5000);
        press("r2_e0", oh(exp_seq[0]));
        botoes = oh(exp_seq[1] + 2'd1);
        tick(1);
        check("wrong_compara", 32'(db_estado), 32'h6);
        botoes = 4'b0000;
        tick(1);
        check("fim_erro", 32'(db_estado), 32'hE);
        check("erro_flags", 32'({pronto, acertou, errou, timeout}), 32'hA);

        // No press: timeout after exactly TT waiting cycles.
        start_game();
        wait_state("espera_to", 4'h5, 5000);
        k = 0;
        while (db_estado == 4'h5 && k < 6000) begin tick(1); k++; end
        check("espera_len", 32'(k), 32'(TT));
        check("fim_timeout", 32'(db_estado), 32'hF);
        check("timeout_flags", 32'({pronto, acertou, errou, timeout}), 32'h9);
        check("timeout_leds", 32'(leds), 32'h0);

        // Press in the last waiting cycle beats the timeout.
        start_game();
        wait_state("espera_late", 4'h5, 5000);
        tick(TT - 1);
        botoes = oh(exp_seq[0]);
        tick(1);
        check("late_compara", 32'(db_estado), 32'h6);
        botoes = 4'b0000;
        tick(1);
        check("late_gera", 32'(db_estado), 32'h2);

        // Button held across entry into waiting does not count.
        botoes = oh(exp_seq[0]);
        wait_state("espera_held", 4'h5, 5000);
        tick(5);
        check("held_no_play", 32'(db_estado), 32'h5);
        botoes = 4'b0000;
        tick(2);
        check("released_wait", 32'(db_estado), 32'h5);
        press("held_e0", oh(exp_seq[0]));
        press("held_e1", oh(exp_seq[1]));

        // Two buttons together is an error.
        wait_state("espera_dual", 4'h5, 5000);
        botoes = 4'b0011;
        tick(1);
        check("dual_compara", 32'(db_estado), 32'h6);
        botoes = 4'b0000;
        tick(1);
        check("dual_erro", 32'(db_estado), 32'hE);
        check("dual_flags", 32'({pronto, acertou, errou, timeout}), 32'hA);

        // Reset during display of round 3, then the same sequence again.
        start_game();
        play_round(0);
        play_round(1);
        play_round(2);
        wait_state("r3_mostra", 4'h3, 10);
        check("r3_rodada", 32'(db_rodada), 32'h3);
        reset = 1'b1;
        #1;
        check("abort_estado", 32'(db_estado), 32'h0);
        check("abort_outs", 32'({leds, pronto, acertou, errou, timeout}), 32'h0);
        check("abort_dbg", 32'({db_rodada, db_endereco, db_jogada}), 32'h0);
        tick(2);
        reset = 1'b0;
        tick(1);
        start_game();
        tick(2);
        check("repeat_leds0", 32'(leds), 32'(oh(exp_seq[0])));
        for (int r = 0; r < 4; r++) play_round(r);
        wait_state("repeat_espera", 4'h5, 5000);
        check("repeat_rodada", 32'(db_rodada), 32'h4);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
